// File: rtl/way3_tmr_pkg.sv
// Shared types and constants for the triplicated register bank.
// No logic; holds the scrub FSM state encoding and copy indices.
// Imported by the bank top and by the voter.
package way3_tmr_pkg;

  // Background scrub sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FIX   = 2'd2
  } scrub_state_t;

  // Copy selectors; the fourth encoding of a 2-bit selector means "no copy".
  localparam logic [1:0] COPY0    = 2'd0;
  localparam logic [1:0] COPY1    = 2'd1;
  localparam logic [1:0] COPY2    = 2'd2;
  localparam logic [1:0] COPY_NONE = 2'd3;
  localparam int         NCOPY    = 3;

endpackage

// File: rtl/way3w_voter.sv
// Single-word 2-of-3 voter over whole words (not bitwise).
// Purely combinational, zero latency.
// No flow control.
module way3w_voter #(
  parameter int W = 32
) (
  input  logic [W-1:0] copy0_i,
  input  logic [W-1:0] copy1_i,
  input  logic [W-1:0] copy2_i,
  output logic [W-1:0] data_o,
  output logic         err1_o,
  output logic         err2_o
);

  logic eq01;
  logic eq02;
  logic eq12;

  assign eq01 = (copy0_i == copy1_i);
  assign eq02 = (copy0_i == copy2_i);
  assign eq12 = (copy1_i == copy2_i);

  // Pick the majority word; flag any disagreement, and flag no-majority separately.
  always_comb begin
    data_o = copy0_i;
    err1_o = 1'b0;
    err2_o = 1'b0;
    if (eq01) begin
      err1_o = !eq02;
    end else begin
      err1_o = 1'b1;
      if (eq02) begin
        data_o = copy0_i;
      end else if (eq12) begin
        data_o = copy1_i;
      end else begin
        data_o = copy0_i;
        err2_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/way3_tmr_regfile.sv
// Triplicated register bank with voted reads, fault injection and background scrub.
// Read data/flags registered one cycle after the address; writes land at the clock edge.
// No backpressure: writes, injections and reads are accepted every cycle.
module way3_tmr_regfile
  import way3_tmr_pkg::*;
#(
  parameter int W            = 32,
  parameter int D            = 16,
  parameter int SCRUB_PERIOD = 64,
  parameter int CNT_W        = 16,
  localparam int AW          = $clog2(D)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [W-1:0]     rd_data_o,
  output logic             rd_error1_o,
  output logic             rd_error2_o,
  input  logic             inj_en_i,
  input  logic [1:0]       inj_copy_i,
  input  logic [AW-1:0]    inj_addr_i,
  input  logic [W-1:0]     inj_mask_i,
  input  logic             scrub_en_i,
  output logic             scrub_busy_o,
  input  logic             clr_i,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] uncorr_cnt_o,
  output logic             uncorr_flag_o,
  output logic [AW-1:0]    uncorr_addr_o
);

  localparam int           TW   = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [TW-1:0] TMAX = TW'(SCRUB_PERIOD - 1);

  typedef struct packed {
    logic [W-1:0] data;
    logic         err1;
    logic         err2;
  } vote_res_t;

  // Storage and state
  logic [W-1:0]     mem_q [NCOPY][D];
  logic [W-1:0]     mem_d [NCOPY][D];
  scrub_state_t     state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  vote_res_t        chk_q, chk_d;
  logic             hit_q, hit_d;
  vote_res_t        rd_q, rd_d;
  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] uncorr_q, uncorr_d;
  logic             flag_q, flag_d;
  logic [AW-1:0]    uaddr_q, uaddr_d;

  // Control
  vote_res_t rd_vote;
  vote_res_t sc_vote;
  logic      inj_valid;
  logic      inj_apply;
  logic      ptr_touched;
  logic      scrub_wb;
  logic      corr_inc;
  logic      uncorr_ev;

  way3w_voter #(.W(W)) u_rd_voter (
    .copy0_i (mem_q[0][rd_addr_i]),
    .copy1_i (mem_q[1][rd_addr_i]),
    .copy2_i (mem_q[2][rd_addr_i]),
    .data_o  (rd_vote.data),
    .err1_o  (rd_vote.err1),
    .err2_o  (rd_vote.err2)
  );

  way3w_voter #(.W(W)) u_sc_voter (
    .copy0_i (mem_q[0][ptr_q]),
    .copy1_i (mem_q[1][ptr_q]),
    .copy2_i (mem_q[2][ptr_q]),
    .data_o  (sc_vote.data),
    .err1_o  (sc_vote.err1),
    .err2_o  (sc_vote.err2)
  );

  // A functional write to the injection address swallows the injection.
  assign inj_valid   = inj_en_i && (inj_copy_i != COPY_NONE);
  assign inj_apply   = inj_valid && !(wr_en_i && (wr_addr_i == inj_addr_i));
  assign ptr_touched = (wr_en_i && (wr_addr_i == ptr_q)) ||
                       (inj_valid && (inj_addr_i == ptr_q));

  // Scrub sequencer: idle timer, then snapshot the vote, then decide on writeback.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ptr_d     = ptr_q;
    chk_d     = chk_q;
    hit_d     = hit_q;
    scrub_wb  = 1'b0;
    corr_inc  = 1'b0;
    uncorr_ev = 1'b0;
    case (state_q)
      IDLE: begin
        if (scrub_en_i) begin
          if (timer_q == TMAX) begin
            timer_d = '0;
            state_d = CHECK;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else begin
          timer_d = '0;
        end
      end
      CHECK: begin
        chk_d   = sc_vote;
        hit_d   = ptr_touched;
        state_d = FIX;
      end
      FIX: begin
        // Any traffic to the entry since the snapshot makes the snapshot stale.
        if (!(hit_q || ptr_touched)) begin
          if (chk_q.err1 && !chk_q.err2) begin
            scrub_wb = 1'b1;
            corr_inc = 1'b1;
          end else if (chk_q.err2) begin
            uncorr_ev = 1'b1;
          end
        end
        ptr_d   = ptr_q + AW'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next storage contents: scrub writeback, then injection, then functional write on top.
  always_comb begin
    mem_d = mem_q;
    if (scrub_wb) begin
      for (int c = 0; c < NCOPY; c++) begin
        mem_d[c][ptr_q] = chk_q.data;
      end
    end
    if (inj_apply) begin
      case (inj_copy_i)
        COPY0:   mem_d[0][inj_addr_i] = mem_q[0][inj_addr_i] ^ inj_mask_i;
        COPY1:   mem_d[1][inj_addr_i] = mem_q[1][inj_addr_i] ^ inj_mask_i;
        COPY2:   mem_d[2][inj_addr_i] = mem_q[2][inj_addr_i] ^ inj_mask_i;
        default: ;
      endcase
    end
    if (wr_en_i) begin
      for (int c = 0; c < NCOPY; c++) begin
        mem_d[c][wr_addr_i] = wr_data_i;
      end
    end
  end

  // Saturating counters and sticky flag; a clear beats a same-cycle increment.
  always_comb begin
    rd_d     = rd_vote;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    flag_d   = flag_q;
    uaddr_d  = uaddr_q;
    if (corr_inc && (corr_q != {CNT_W{1'b1}})) begin
      corr_d = corr_q + CNT_W'(1);
    end
    if (uncorr_ev) begin
      if (uncorr_q != {CNT_W{1'b1}}) begin
        uncorr_d = uncorr_q + CNT_W'(1);
      end
      flag_d  = 1'b1;
      uaddr_d = ptr_q;
    end
    if (clr_i) begin
      corr_d   = '0;
      uncorr_d = '0;
      flag_d   = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '{default: '0}};
      state_q  <= IDLE;
      timer_q  <= '0;
      ptr_q    <= '0;
      chk_q    <= '0;
      hit_q    <= 1'b0;
      rd_q     <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
      flag_q   <= 1'b0;
      uaddr_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      ptr_q    <= ptr_d;
      chk_q    <= chk_d;
      hit_q    <= hit_d;
      rd_q     <= rd_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      flag_q   <= flag_d;
      uaddr_q  <= uaddr_d;
    end
  end

  assign rd_data_o     = rd_q.data;
  assign rd_error1_o   = rd_q.err1;
  assign rd_error2_o   = rd_q.err2;
  assign scrub_busy_o  = (state_q == CHECK) || (state_q == FIX);
  assign corr_cnt_o    = corr_q;
  assign uncorr_cnt_o  = uncorr_q;
  assign uncorr_flag_o = flag_q;
  assign uncorr_addr_o = uaddr_q;

endmodule
